// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width and the bypass-bus packing
// used by the EXE/MEM/WB producers and every operand consumer.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;

    // Bypass buses are flat vectors with port b's field starting at b*width.
    localparam int BYP_ADDR_W = REG_ADDR_W;

    function automatic int byp_addr_lsb(input int b);
        return b * BYP_ADDR_W;
    endfunction

    function automatic int byp_data_lsb(input int b, input int xlen);
        return b * xlen;
    endfunction

endpackage

// File: rtl/operand_select.sv
// Resolves one source slot: immediate, hard-wired r0, youngest matching
// bypass port, or register-file data, in that priority.
module operand_select
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = 3
) (
    input  logic                          en_i,
    input  logic [REG_ADDR_W-1:0]         addr_i,
    input  logic [XLEN-1:0]               imm_i,
    input  logic [XLEN-1:0]               rf_rdata_i,
    input  logic [NUM_BYP-1:0]            byp_valid_i,
    input  logic [NUM_BYP-1:0]            byp_wen_i,
    input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_addr_i,
    input  logic [NUM_BYP-1:0]            byp_data_ok_i,
    input  logic [NUM_BYP*XLEN-1:0]       byp_data_i,
    output logic [XLEN-1:0]               operand_o,
    output logic                          ready_o
);

    logic hit;

    always_comb begin
        operand_o = '0;
        ready_o   = 1'b1;
        hit       = 1'b0;
        if (!en_i) begin
            operand_o = imm_i;
        end else if (addr_i != '0) begin
            operand_o = rf_rdata_i;
            // Ascending scan with a sticky hit flag makes the youngest port win.
            for (int b = 0; b < NUM_BYP; b++) begin
                if (!hit && byp_valid_i[b] && byp_wen_i[b] &&
                    byp_addr_i[byp_addr_lsb(b) +: REG_ADDR_W] == addr_i) begin
                    hit       = 1'b1;
                    ready_o   = byp_data_ok_i[b];
                    operand_o = byp_data_ok_i[b] ? byp_data_i[byp_data_lsb(b, XLEN) +: XLEN] : '0;
                end
            end
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// Single-entry decode-to-execute issue stage: holds one instruction, gathers
// its operands from RF/bypass/immediate and issues with valid/ready.
module operand_issue_stage
    import cpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 3,
    parameter int NUM_BYP   = 3,
    parameter int PAYLOAD_W = 96
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic [NUM_SRC-1:0]            in_src_en,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] in_src_addr,
    input  logic [NUM_SRC*XLEN-1:0]       in_src_imm,
    output logic [NUM_SRC*REG_ADDR_W-1:0] rf_raddr,
    input  logic [NUM_SRC*XLEN-1:0]       rf_rdata,
    input  logic [NUM_BYP-1:0]            byp_valid,
    input  logic [NUM_BYP-1:0]            byp_wen,
    input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_addr,
    input  logic [NUM_BYP-1:0]            byp_data_ok,
    input  logic [NUM_BYP*XLEN-1:0]       byp_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PAYLOAD_W-1:0]          out_payload,
    output logic [NUM_SRC*XLEN-1:0]       out_src,
    output logic [31:0]                   stall_cnt
);

    typedef struct packed {
        logic                          valid;
        logic [PAYLOAD_W-1:0]          payload;
        logic [NUM_SRC-1:0]            src_en;
        logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
        logic [NUM_SRC*XLEN-1:0]       src_imm;
    } entry_t;

    entry_t                  entry_q, entry_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0]      slot_ready;
    logic [NUM_SRC*XLEN-1:0] slot_operand;
    logic                    all_ready;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
        operand_select #(
            .XLEN    (XLEN),
            .NUM_BYP (NUM_BYP)
        ) u_sel (
            .en_i          (entry_q.src_en[s]),
            .addr_i        (entry_q.src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
            .imm_i         (entry_q.src_imm[s*XLEN +: XLEN]),
            .rf_rdata_i    (rf_rdata[s*XLEN +: XLEN]),
            .byp_valid_i   (byp_valid),
            .byp_wen_i     (byp_wen),
            .byp_addr_i    (byp_addr),
            .byp_data_ok_i (byp_data_ok),
            .byp_data_i    (byp_data),
            .operand_o     (slot_operand[s*XLEN +: XLEN]),
            .ready_o       (slot_ready[s])
        );
    end

    assign all_ready   = &slot_ready;
    assign out_valid   = entry_q.valid & all_ready & ~flush;
    assign out_payload = entry_q.payload;
    assign out_src     = entry_q.valid ? slot_operand : '0;
    assign rf_raddr    = entry_q.src_addr;
    // Deliberately flush-independent so upstream never sees a flush-to-ready path.
    assign in_ready    = ~entry_q.valid | (all_ready & out_ready);
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (in_ready) begin
            entry_d.valid = in_valid;
            if (in_valid) begin
                entry_d.payload  = in_payload;
                entry_d.src_en   = in_src_en;
                entry_d.src_addr = in_src_addr;
                entry_d.src_imm  = in_src_imm;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (entry_q.valid && !all_ready && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            entry_q     <= entry_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Parametrised decode-to-execute issue stage that holds one decoded instruction and collects NUM_SRC source operands. Each operand comes from the register file, from a priority-ordered set of NUM_BYP bypass ports, or from an immediate. The stage issues the instruction to execute with a valid/ready handshake, and supports a flush on branch mispredict. It also keeps a saturating operand-stall counter. It replaces the fixed two-source, three-bypass decode stage and closes its gaps: valid gating on every bypass compare, no forwarding of r0, and a per-source store-data path.

## Interface
- XLEN, 32, operand width
- NUM_SRC, 3, operand slots (e.g. alu src1, alu src2, store data)
- NUM_BYP, 3, bypass ports; index 0 = youngest (EXE), then MEM, WB
- PAYLOAD_W, 96, opaque decoded-control payload carried alongside the operands
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_payload  in  PAYLOAD_W  decoded control
- in_src_en  in  NUM_SRC  per slot: 1 = register operand, 0 = use immediate
- in_src_addr  in  NUM_SRC*5  per-slot source register number
- in_src_imm  in  NUM_SRC*XLEN  per-slot immediate/PC/constant
- rf_raddr  out  NUM_SRC*5  register-file read addresses (from the held entry)
- rf_rdata  in  NUM_SRC*XLEN  combinational register-file read data
- byp_valid  in  NUM_BYP  producing stage holds a valid instruction
- byp_wen  in  NUM_BYP  that instruction writes a register
- byp_addr  in  NUM_BYP*5  destination register
- byp_data_ok  in  NUM_BYP  result already available in that stage
- byp_data  in  NUM_BYP*XLEN  result value
- flush  in  1  mispredict/cancel; kills the held and incoming instruction
- out_valid  out  1  instruction and all operands ready
- out_ready  in  1  execute accepts
- out_payload  out  PAYLOAD_W  held payload
- out_src  out  NUM_SRC*XLEN  resolved operands
- stall_cnt  out  32  cycles spent valid but waiting on operands, saturating

## Operation
- Holding register: one entry {valid, payload, src_en, src_addr, src_imm}. No extra buffering.
- Per slot s, resolution is combinational every cycle, first rule wins:
  - src_en=0: operand = imm, ready.
  - addr=0: operand = 0, ready; bypass is never consulted.
  - Lowest index b with byp_valid & byp_wen & byp_addr==addr:
    - data_ok=1: operand = byp_data[b], ready.
    - data_ok=0: not ready, operand forced to 0.
  - Otherwise: operand = rf_rdata[s], ready.
- all_ready = AND over slots. go = valid & all_ready & ~flush.
- out_valid = go. out_src/out_payload are held-entry values; out_src is 0 when valid=0.
- in_ready = ~valid | (all_ready & out_ready). in_ready is independent of flush.
- Register update, in priority order:
  - reset: valid=0, fields 0.
  - flush: valid=0.
  - in_ready: valid<=in_valid, load fields when in_valid.
  - otherwise hold.
- stall_cnt: +1 when valid & ~all_ready & ~flush; holds at 0xFFFF_FFFF; cleared only by reset.

## Timing
- Reset outputs: out_valid 0, in_ready 1, out_src 0, out_payload 0, rf_raddr 0, stall_cnt 0.
- Latency: accept in cycle N, out_valid earliest in N+1. With continuous out_ready and no hazards, throughput is one instruction per cycle.
- A bypass value or a data_ok rise in cycle N is visible on out_src/out_valid in the same cycle N. The path is combinational.
- Simultaneous flush and in_valid: the incoming instruction is dropped; valid=0 next cycle.
- Simultaneous flush and out_ready: no handshake, since out_valid is 0.
- Two bypass ports matching the same register: the lowest index (youngest) wins.
- Reset mid-stall: entry dropped and counter cleared on the next edge.

## Structure
- Shared package cpu_pkg holds REG_ADDR_W=5 and bypass-port field offsets/widths. The bypass-bus packing is shared with the EXE/MEM/WB stages.
- Sub-module operand_select: one slot's priority resolution (inputs: en, addr, imm, rf_rdata, bypass vectors; outputs: operand, ready). It is instantiated NUM_SRC times via generate.
- Top level contains the holding register, handshake logic and stall counter.

## Test plan
- Reset, then in_valid with src_en=000 and imm={1,2,3}, out_ready=1 -> in cycle 1, out_valid=1 and out_src={1,2,3}; stall_cnt=0.
- src1 addr 5; byp0 and byp2 both write r5, data_ok=1, data 0xAAAA/0xBBBB -> out_src[0]=0xAAAA. Drop byp0 valid -> 0xBBBB.
- src2 addr 7; byp1 writes r7 with data_ok=0 for 3 cycles, then 1 with 0x1234 -> out_valid low for 3 cycles, stall_cnt=3, in_ready=0; then out_valid=1 with 0x1234.
- src addr 0 with byp0 writing r0 data 0xDEAD -> operand 0, ready.
- Held entry stalled plus in_valid, then flush -> next cycle valid=0 and out_valid=0; the incoming instruction is not issued.
- out_ready=0 with ready operands -> entry holds and in_ready=0, payload stable; out_ready=1 -> transfer, and new entry accepted the same cycle.
